// File: rtl/hamming_pkg.sv
// Shared types and constant helpers for the streaming Hamming decoder.
// HAMMING_SECDED_EN adds a trailing overall-parity bit to the codeword.
package hamming_pkg;

    typedef enum logic [1:0] {
        ST_OK,
        ST_CORR,
        ST_UNCORR
    } dec_status_e;

    function automatic int cw_width(input int data_bit, input int parity_bit);
`ifdef HAMMING_SECDED_EN
        return data_bit + parity_bit + 1;
`else
        return data_bit + parity_bit;
`endif
    endfunction

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

    // Hamming position of data index idx (idx 0 = lowest data position).
    function automatic int data_pos(input int idx);
        int cnt;
        int pos;
        cnt = 0;
        pos = 0;
        for (int p = 1; p < 128; p++) begin
            if (!is_pow2(p) && pos == 0) begin
                if (cnt == idx) pos = p;
                cnt++;
            end
        end
        return pos;
    endfunction

    // Legal only for the smallest P covering DATA_BIT+P+1 positions.
    function automatic bit params_ok(input int data_bit, input int parity_bit);
        if (data_bit < 4 || data_bit > 57) return 1'b0;
        if (parity_bit < 2 || parity_bit > 7) return 1'b0;
        if ((1 << parity_bit) < data_bit + parity_bit + 1) return 1'b0;
        if ((1 << (parity_bit - 1)) >= data_bit + parity_bit) return 1'b0;
        return 1'b1;
    endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational syndrome: XOR of the Hamming positions of all set bits.
// HAMMING_SECDED_EN adds o_ov, the XOR of every codeword bit.
module hamming_syndrome
    import hamming_pkg::*;
#(
    parameter  int DATA_BIT   = 8,
    parameter  int PARITY_BIT = 4,
    localparam int CW         = cw_width(DATA_BIT, PARITY_BIT)
) (
    input  logic [CW-1:0]         i_code,
`ifdef HAMMING_SECDED_EN
    output logic                  o_ov,
`endif
    output logic [PARITY_BIT-1:0] o_syndrome
);

    localparam int N = DATA_BIT + PARITY_BIT;

    always_comb begin
        o_syndrome = '0;
        for (int p = 1; p <= N; p++) begin
            if (i_code[CW-p]) o_syndrome = o_syndrome ^ PARITY_BIT'(p);
        end
    end

`ifdef HAMMING_SECDED_EN
    assign o_ov = ^i_code;
`endif

endmodule

// File: rtl/hamming_stream_dec.sv
// Two-stage streaming Hamming SEC decoder with valid/ready flow control and
// a saturating corrected-word counter. HAMMING_SECDED_EN enables SECDED mode.
module hamming_stream_dec
    import hamming_pkg::*;
#(
    parameter  int DATA_BIT   = 8,
    parameter  int PARITY_BIT = 4,
    parameter  int CNT_W      = 8,
    localparam int CW         = cw_width(DATA_BIT, PARITY_BIT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CW-1:0]         IN_code,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_BIT-1:0]   OUT_code,
    output logic [PARITY_BIT-1:0] syndrome,
    output logic                  corrected,
    output logic                  uncorrectable,
    output logic [CNT_W-1:0]      err_cnt,
    input  logic                  cnt_clr
);

    localparam int                  N    = DATA_BIT + PARITY_BIT;
    localparam logic [PARITY_BIT-1:0] LP_N = PARITY_BIT'(N);

    generate
        if (!params_ok(DATA_BIT, PARITY_BIT)) begin : g_bad_params
            $fatal(1, "hamming_stream_dec: illegal DATA_BIT/PARITY_BIT pair");
        end
        if (CNT_W < 1) begin : g_bad_cnt
            $fatal(1, "hamming_stream_dec: CNT_W must be at least 1");
        end
    endgenerate

    logic                  w_advance;
    logic [PARITY_BIT-1:0] w_syn;
    logic                  r_s1_valid;
    logic [CW-1:0]         r_s1_code;
    logic [PARITY_BIT-1:0] r_s1_syn;
    dec_status_e           w_status;
    logic                  w_flip;
    logic [CW-1:0]         w_fixed;
    logic [DATA_BIT-1:0]   w_data;
    logic                  w_cnt_inc;
    logic                  r_out_valid;
    logic [DATA_BIT-1:0]   r_out_code;
    logic [PARITY_BIT-1:0] r_syn;
    logic                  r_corr;
    logic                  r_unc;
    logic [CNT_W-1:0]      r_cnt;
`ifdef HAMMING_SECDED_EN
    logic                  w_ov;
    logic                  r_s1_ov;
`endif

    // Both stages move together; a stalled output freezes the whole pipe.
    assign w_advance = !r_out_valid || out_ready;
    assign in_ready  = w_advance;

    hamming_syndrome #(
        .DATA_BIT   (DATA_BIT),
        .PARITY_BIT (PARITY_BIT)
    ) u_syndrome (
        .i_code     (IN_code),
`ifdef HAMMING_SECDED_EN
        .o_ov       (w_ov),
`endif
        .o_syndrome (w_syn)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_code  <= '0;
            r_s1_syn   <= '0;
`ifdef HAMMING_SECDED_EN
            r_s1_ov    <= 1'b0;
`endif
        end else if (w_advance) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_code <= IN_code;
                r_s1_syn  <= w_syn;
`ifdef HAMMING_SECDED_EN
                r_s1_ov   <= w_ov;
`endif
            end
        end
    end

    always_comb begin
        w_status = ST_OK;
        w_flip   = 1'b0;
`ifdef HAMMING_SECDED_EN
        // Zero syndrome with odd overall parity: only the parity bit was hit.
        if (r_s1_syn == '0) begin
            if (r_s1_ov) w_status = ST_CORR;
        end else if (!r_s1_ov || r_s1_syn > LP_N) begin
            w_status = ST_UNCORR;
        end else begin
            w_status = ST_CORR;
            w_flip   = 1'b1;
        end
`else
        if (r_s1_syn != '0) begin
            if (r_s1_syn > LP_N) begin
                w_status = ST_UNCORR;
            end else begin
                w_status = ST_CORR;
                w_flip   = 1'b1;
            end
        end
`endif
    end

    always_comb begin
        w_fixed = r_s1_code;
        for (int p = 1; p <= N; p++) begin
            if (w_flip && r_s1_syn == PARITY_BIT'(p)) w_fixed[CW-p] = ~r_s1_code[CW-p];
        end
    end

    // Lowest data position lands on the payload MSB.
    always_comb begin
        w_data = '0;
        for (int i = 0; i < DATA_BIT; i++) begin
            w_data[DATA_BIT-1-i] = w_fixed[CW-data_pos(i)];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_code  <= '0;
            r_syn       <= '0;
            r_corr      <= 1'b0;
            r_unc       <= 1'b0;
        end else if (w_advance) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_code <= w_data;
                r_syn      <= r_s1_syn;
                r_corr     <= (w_status == ST_CORR);
                r_unc      <= (w_status == ST_UNCORR);
            end
        end
    end

    assign w_cnt_inc = r_out_valid && out_ready && r_corr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (cnt_clr) begin
            r_cnt <= '0;
        end else if (w_cnt_inc && r_cnt != '1) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign out_valid     = r_out_valid;
    assign OUT_code      = r_out_code;
    assign syndrome      = r_syn;
    assign corrected     = r_corr;
    assign uncorrectable = r_unc;
    assign err_cnt       = r_cnt;

endmodule
